// File: rtl/ram_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_write_arbiter_if
// Description : Bundles the two requester handshakes and the RAM write port
//               signals of ram_write_arbiter.
//               master : requester / RAM side (drives valid, addr, data)
//               slave  : arbiter side (drives ready, RAM write port, busy)
// Ports       : req0_valid/addr/data/ready, req1_valid/addr/data/ready,
//               ram_address_write, ram_data_write, ram_write_enable, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_write_arbiter_if #(
   parameter int D_WIDTH = 19,
   parameter int A_WIDTH = 5
);
   logic               req0_valid;
   logic [A_WIDTH-1:0] req0_addr;
   logic [D_WIDTH-1:0] req0_data;
   logic               req0_ready;
   logic               req1_valid;
   logic [A_WIDTH-1:0] req1_addr;
   logic [D_WIDTH-1:0] req1_data;
   logic               req1_ready;
   logic [A_WIDTH-1:0] ram_address_write;
   logic [D_WIDTH-1:0] ram_data_write;
   logic               ram_write_enable;
   logic               busy;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  ram_address_write, ram_data_write, ram_write_enable, busy
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output ram_address_write, ram_data_write, ram_write_enable, busy
   );
endinterface
`default_nettype wire

// File: rtl/ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_write_arbiter
// Description : Shares the single write port of the 32x19 data RAM between
//               requester 0 (core store path) and requester 1 (loader/debug).
//               Valid/ready handshake, round-robin on contention, registered
//               address/data/write-enable toward the RAM.
//               Optional macro RAM_WRITE_ARB_CLEAR_EN compiles in a post-reset
//               sweep that zeroes every RAM word before traffic is accepted.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - ram_write_arbiter_if.slave: requester handshakes,
//                       RAM write port (address, data, enable) and busy
// Revision    : 1.0 - initial release
// ============================================================================
module ram_write_arbiter #(
   parameter int D_WIDTH = 19,
   parameter int A_WIDTH = 5,
   parameter int A_MAX   = 32
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   ram_write_arbiter_if.slave  bus
);

   generate
      if (A_MAX != (1 << A_WIDTH)) begin : g_bad_a_max
         $error("ram_write_arbiter: A_MAX must equal 2**A_WIDTH");
      end
   endgenerate

   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic [D_WIDTH-1:0] data_q, data_d;
   logic               we_q, we_d;
   logic               last_grant_q, last_grant_d;
   logic               run;
   logic               ready0, ready1;

`ifdef RAM_WRITE_ARB_CLEAR_EN
   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [A_WIDTH-1:0] C_LAST_WORD = A_WIDTH'(A_MAX - 1);

   state_t             state_q, state_d;
   logic [A_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

   assign run      = (state_q == ST_RUN);
   assign bus.busy = (state_q == ST_CLEAR);
`else
   // No sweep: the block is in RUN whenever reset is released. Gating with
   // rst_n keeps both ready outputs low while reset is held.
   assign run      = rst_n;
   assign bus.busy = 1'b0;
`endif

   // Winner selection: a lone valid requester wins; on a tie the requester
   // that did not win last time is served.
   always_comb begin
      ready0 = run && bus.req0_valid && (!bus.req1_valid ||  last_grant_q);
      ready1 = run && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;

   always_comb begin
      addr_d       = addr_q;
      data_d       = data_q;
      we_d         = 1'b0;
      last_grant_d = last_grant_q;
`ifdef RAM_WRITE_ARB_CLEAR_EN
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
`endif
      if (ready0) begin
         addr_d       = bus.req0_addr;
         data_d       = bus.req0_data;
         we_d         = 1'b1;
         last_grant_d = 1'b0;
      end else if (ready1) begin
         addr_d       = bus.req1_addr;
         data_d       = bus.req1_data;
         we_d         = 1'b1;
         last_grant_d = 1'b1;
      end
`ifdef RAM_WRITE_ARB_CLEAR_EN
      // Both readies are low in CLEAR, so this overrides nothing live.
      if (state_q == ST_CLEAR) begin
         addr_d    = clr_cnt_q;
         data_d    = '0;
         we_d      = 1'b1;
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == C_LAST_WORD) begin
            state_d = ST_RUN;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         last_grant_q <= 1'b1;
`ifdef RAM_WRITE_ARB_CLEAR_EN
         state_q      <= ST_CLEAR;
         clr_cnt_q    <= '0;
`endif
      end else begin
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_q         <= we_d;
         last_grant_q <= last_grant_d;
`ifdef RAM_WRITE_ARB_CLEAR_EN
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
`endif
      end
   end

   assign bus.ram_address_write = addr_q;
   assign bus.ram_data_write    = data_q;
   assign bus.ram_write_enable  = we_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_write_arbiter
// Description : Self-checking bench for ram_write_arbiter: directed vector
//               table, randomized traffic against a behavioural model, sweep
//               and mid-stream reset sequences (sweep parts active when
//               RAM_WRITE_ARB_CLEAR_EN is defined), final RAM content check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_write_arbiter;
   localparam int D_WIDTH = 19;
   localparam int A_WIDTH = 5;
   localparam int A_MAX   = 32;
`ifdef RAM_WRITE_ARB_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_write_arbiter_if #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) bus ();

   ram_write_arbiter #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .A_MAX(A_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Behaves as the RAM write port: captures whatever is presented at an edge.
   logic [D_WIDTH-1:0] ram_shadow [A_MAX];
   always @(posedge clk) begin
      if (bus.ram_write_enable === 1'b1) ram_shadow[bus.ram_address_write] <= bus.ram_data_write;
   end

   // Reference model state
   logic [D_WIDTH-1:0] ref_mem     [A_MAX];
   bit                 ref_written [A_MAX];
   bit                 m_we;
   logic [A_WIDTH-1:0] m_addr;
   logic [D_WIDTH-1:0] m_data;
   int                 m_last;

   typedef struct {
      bit                 v0;
      logic [A_WIDTH-1:0] a0;
      logic [D_WIDTH-1:0] d0;
      bit                 v1;
      logic [A_WIDTH-1:0] a1;
      logic [D_WIDTH-1:0] d1;
      bit                 er0;
      bit                 er1;
      logic [A_WIDTH-1:0] ea;
      logic [D_WIDTH-1:0] ed;
      bit                 ewe;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Round-robin rule: lone valid wins; tie goes to the one not served last.
   function automatic int pick(input bit v0, input bit v1, input int last);
      if (v0 && v1) return 1 - last;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_last = 1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " ready0"}, {31'd0, bus.req0_ready}, 32'd0);
      chk({tag, " ready1"}, {31'd0, bus.req1_ready}, 32'd0);
      chk({tag, " addr"}, {27'd0, bus.ram_address_write}, 32'd0);
      chk({tag, " data"}, {13'd0, bus.ram_data_write}, 32'd0);
      chk({tag, " we"}, {31'd0, bus.ram_write_enable}, 32'd0);
      chk({tag, " busy"}, {31'd0, bus.busy}, {31'd0, CLEAR_EN});
   endtask

   // One clock cycle: drive, check ready, clock, check the registered port.
   task automatic run_cycle(input bit v0, input logic [A_WIDTH-1:0] a0, input logic [D_WIDTH-1:0] d0,
                            input bit v1, input logic [A_WIDTH-1:0] a1, input logic [D_WIDTH-1:0] d1,
                            input bit er0, input bit er1,
                            input logic [A_WIDTH-1:0] ea, input logic [D_WIDTH-1:0] ed,
                            input bit ewe, input bit ebusy, input string tag);
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      bus.req1_data  = d1;
      #1;
      chk({tag, " ready0"}, {31'd0, bus.req0_ready}, {31'd0, er0});
      chk({tag, " ready1"}, {31'd0, bus.req1_ready}, {31'd0, er1});
      @(posedge clk);
      if (m_we) begin
         ref_mem[m_addr]     = m_data;
         ref_written[m_addr] = 1'b1;
      end
      m_we   = ewe;
      m_addr = ea;
      m_data = ed;
      if (v0 && er0) m_last = 0;
      else if (v1 && er1) m_last = 1;
      #1;
      chk({tag, " addr"}, {27'd0, bus.ram_address_write}, {27'd0, ea});
      chk({tag, " data"}, {13'd0, bus.ram_data_write}, {13'd0, ed});
      chk({tag, " we"}, {31'd0, bus.ram_write_enable}, {31'd0, ewe});
      chk({tag, " busy"}, {31'd0, bus.busy}, {31'd0, ebusy});
   endtask

   // A cycle whose expectations come from the model rules.
   task automatic model_cycle(input bit v0, input logic [A_WIDTH-1:0] a0, input logic [D_WIDTH-1:0] d0,
                              input bit v1, input logic [A_WIDTH-1:0] a1, input logic [D_WIDTH-1:0] d1,
                              input string tag, output int w);
      logic [A_WIDTH-1:0] ea;
      logic [D_WIDTH-1:0] ed;
      w  = pick(v0, v1, m_last);
      ea = (w == 0) ? a0 : (w == 1) ? a1 : m_addr;
      ed = (w == 0) ? d0 : (w == 1) ? d1 : m_data;
      run_cycle(v0, a0, d0, v1, a1, d1, (w == 0), (w == 1), ea, ed, (w >= 0), 1'b0, tag);
   endtask

`ifdef RAM_WRITE_ARB_CLEAR_EN
   // Sweep: word i written at edge i+1, busy drops at edge A_MAX.
   task automatic sweep(input bit v0_on, input int v1_from,
                        input logic [A_WIDTH-1:0] a0, input logic [D_WIDTH-1:0] d0,
                        input logic [A_WIDTH-1:0] a1, input logic [D_WIDTH-1:0] d1);
      for (int i = 0; i < A_MAX; i++) begin
         run_cycle(v0_on, a0, d0, (i >= v1_from), a1, d1, 1'b0, 1'b0,
                   A_WIDTH'(i), '0, 1'b1, (i != A_MAX - 1), $sformatf("sweep%0d", i));
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bit p0, p1, rv0, rv1;
      logic [A_WIDTH-1:0] ra0, ra1;
      logic [D_WIDTH-1:0] rd0, rd1;

      tbl[0]  = '{1'b1, 5'd1, 19'h00111, 1'b1, 5'd2,  19'h00222, 1'b1, 1'b0, 5'd1,  19'h00111, 1'b1};
      tbl[1]  = '{1'b1, 5'd1, 19'h00111, 1'b1, 5'd2,  19'h00222, 1'b0, 1'b1, 5'd2,  19'h00222, 1'b1};
      tbl[2]  = '{1'b1, 5'd1, 19'h00111, 1'b1, 5'd2,  19'h00222, 1'b1, 1'b0, 5'd1,  19'h00111, 1'b1};
      tbl[3]  = '{1'b1, 5'd1, 19'h00111, 1'b1, 5'd2,  19'h00222, 1'b0, 1'b1, 5'd2,  19'h00222, 1'b1};
      tbl[4]  = '{1'b1, 5'd1, 19'h00111, 1'b1, 5'd2,  19'h00222, 1'b1, 1'b0, 5'd1,  19'h00111, 1'b1};
      tbl[5]  = '{1'b1, 5'd1, 19'h00111, 1'b1, 5'd2,  19'h00222, 1'b0, 1'b1, 5'd2,  19'h00222, 1'b1};
      tbl[6]  = '{1'b1, 5'd5, 19'h1ABCD, 1'b0, 5'd0,  19'h00000, 1'b1, 1'b0, 5'd5,  19'h1ABCD, 1'b1};
      tbl[7]  = '{1'b0, 5'd0, 19'h00000, 1'b0, 5'd0,  19'h00000, 1'b0, 1'b0, 5'd5,  19'h1ABCD, 1'b0};
      tbl[8]  = '{1'b0, 5'd0, 19'h00000, 1'b1, 5'd31, 19'h7FFFF, 1'b0, 1'b1, 5'd31, 19'h7FFFF, 1'b1};
      tbl[9]  = '{1'b1, 5'd0, 19'h00000, 1'b1, 5'd3,  19'h00003, 1'b1, 1'b0, 5'd0,  19'h00000, 1'b1};
      tbl[10] = '{1'b1, 5'd4, 19'h2AAAA, 1'b0, 5'd0,  19'h00000, 1'b1, 1'b0, 5'd4,  19'h2AAAA, 1'b1};
      tbl[11] = '{1'b1, 5'd6, 19'h00006, 1'b1, 5'd6,  19'h00016, 1'b0, 1'b1, 5'd6,  19'h00016, 1'b1};
      tbl[12] = '{1'b1, 5'd6, 19'h00006, 1'b1, 5'd6,  19'h00016, 1'b1, 1'b0, 5'd6,  19'h00006, 1'b1};
      tbl[13] = '{1'b0, 5'd0, 19'h00000, 1'b0, 5'd0,  19'h00000, 1'b0, 1'b0, 5'd6,  19'h00006, 1'b0};

      bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
      for (int i = 0; i < A_MAX; i++) ref_written[i] = 1'b0;
      model_reset();

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // First request: held off by the sweep, or accepted at edge 1 without it
`ifdef RAM_WRITE_ARB_CLEAR_EN
      sweep(1'b0, 2, 5'd0, 19'h0, 5'd7, 19'h15555);
      run_cycle(1'b0, 5'd0, 19'h0, 1'b1, 5'd7, 19'h15555, 1'b0, 1'b1, 5'd7, 19'h15555, 1'b1, 1'b0, "post_sweep_accept");
`else
      run_cycle(1'b0, 5'd0, 19'h0, 1'b1, 5'd7, 19'h15555, 1'b0, 1'b1, 5'd7, 19'h15555, 1'b1, 1'b0, "first_cycle_accept");
`endif
      run_cycle(1'b0, 5'd0, 19'h0, 1'b0, 5'd0, 19'h0, 1'b0, 1'b0, 5'd7, 19'h15555, 1'b0, 1'b0, "we_falls");

      // Directed vector table
      for (int i = 0; i < 14; i++) begin
         run_cycle(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
                   tbl[i].er0, tbl[i].er1, tbl[i].ea, tbl[i].ed, tbl[i].ewe, 1'b0,
                   $sformatf("tbl%0d", i));
      end

      // Randomized traffic; a losing requester holds its request or drops it
      p0 = 1'b0; p1 = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
      ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
      for (int n = 0; n < 400; n++) begin
         if (p0) begin
            if ($urandom_range(0, 9) == 0) rv0 = 1'b0;
         end else begin
            rv0 = ($urandom_range(0, 2) != 0);
            ra0 = A_WIDTH'($urandom_range(0, A_MAX - 1));
            rd0 = D_WIDTH'($urandom);
         end
         if (p1) begin
            if ($urandom_range(0, 9) == 0) rv1 = 1'b0;
         end else begin
            rv1 = ($urandom_range(0, 2) != 0);
            ra1 = A_WIDTH'($urandom_range(0, A_MAX - 1));
            rd1 = D_WIDTH'($urandom);
         end
         model_cycle(rv0, ra0, rd0, rv1, ra1, rd1, $sformatf("rand%0d", n), w);
         p0 = rv0 && (w != 0);
         p1 = rv1 && (w != 1);
      end

      // Reset while both requesters stream
      model_cycle(1'b1, 5'd9, 19'h12345, 1'b1, 5'd10, 19'h0ABCD, "stream", w);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef RAM_WRITE_ARB_CLEAR_EN
      sweep(1'b1, 0, 5'd9, 19'h12345, 5'd10, 19'h0ABCD);
`endif
      run_cycle(1'b1, 5'd9, 19'h12345, 1'b1, 5'd10, 19'h0ABCD, 1'b1, 1'b0, 5'd9, 19'h12345, 1'b1, 1'b0, "tie_after_reset");
      run_cycle(1'b0, 5'd9, 19'h12345, 1'b1, 5'd10, 19'h0ABCD, 1'b0, 1'b1, 5'd10, 19'h0ABCD, 1'b1, 1'b0, "tie_second");
      run_cycle(1'b0, 5'd0, 19'h0, 1'b0, 5'd0, 19'h0, 1'b0, 1'b0, 5'd10, 19'h0ABCD, 1'b0, 1'b0, "idle0");
      run_cycle(1'b0, 5'd0, 19'h0, 1'b0, 5'd0, 19'h0, 1'b0, 1'b0, 5'd10, 19'h0ABCD, 1'b0, 1'b0, "idle1");

      // RAM contents seen through the write port versus the model
      for (int a = 0; a < A_MAX; a++) begin
         if (ref_written[a]) begin
            chk($sformatf("ram[%0d]", a), {13'd0, ram_shadow[a]}, {13'd0, ref_mem[a]});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
